// File: rtl/lzc_pipe.sv
// Pipelined leading/trailing zero, leading one and redundant-sign counter with normalising shift.
// Stage 0 builds a search vector and nibble flags; the last stage does priority combine and shift.
module lzc_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(WIDTH)-1:0] out_count,
  output logic                     out_flag,
  output logic [WIDTH-1:0]         out_norm,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int CW = $clog2(WIDTH);
  localparam int NG = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       mode;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] srch;
    logic [NG-1:0]    gnz;
    logic [CW-1:0]    count;
    logic             flag;
    logic [WIDTH-1:0] norm;
  } pay_t;

  // Every mode is mapped onto a leading-zero search of srch. For LS the sign-compared
  // lower bits get a zero appended so an all-equal operand reads as an all-zero vector.
  function automatic pay_t prep(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                input logic [TAG_W-1:0] t);
    pay_t p;
    p      = '0;
    p.data = d;
    p.mode = m;
    p.tag  = t;
    case (m)
      2'd0: p.srch = d;
      2'd1: p.srch = ~d;
      2'd2: for (int i = 0; i < int'(WIDTH); i++) p.srch[i] = d[int'(WIDTH)-1-i];
      default: p.srch = {d[WIDTH-2:0] ^ {(WIDTH-1){d[WIDTH-1]}}, 1'b0};
    endcase
    for (int g = 0; g < NG; g++) p.gnz[g] = |p.srch[4*g +: 4];
    return p;
  endfunction

  function automatic pay_t fin(input pay_t p);
    pay_t r;
    int   cnt;
    r   = p;
    cnt = 0;
    // Ascending scan: the highest non-empty nibble is written last and wins.
    for (int g = 0; g < NG; g++) begin
      if (p.gnz[g]) begin
        cnt = 4 * (NG - 1 - g) + (p.srch[4*g+3] ? 0 : p.srch[4*g+2] ? 1 :
                                  p.srch[4*g+1] ? 2 : 3);
      end
    end
    r.flag = ~|p.gnz;
    if (r.flag) cnt = int'(WIDTH) - 1;
    r.count = CW'(cnt);
    r.norm  = (p.mode == 2'd2) ? (p.data >> r.count) : (p.data << r.count);
    return r;
  endfunction

  pay_t            stg_q  [PIPE];
  pay_t            stg_in [PIPE];
  logic [PIPE-1:0] v_q;
  logic [PIPE-1:0] vin;
  logic [PIPE-1:0] rdy;

  always_comb begin
    stg_in[0] = prep(in_data, in_mode, in_tag);
    vin[0]    = in_valid;
    for (int k = 1; k < int'(PIPE); k++) begin
      stg_in[k] = stg_q[k-1];
      vin[k]    = v_q[k-1];
    end
    stg_in[PIPE-1] = fin(stg_in[PIPE-1]);
    // A stage may load if any stage at or after it is empty, or the output drains.
    for (int k = 0; k < int'(PIPE); k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < int'(PIPE); j++) begin
        if (!v_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < int'(PIPE); k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(PIPE); k++) begin
        if (rdy[k]) begin
          v_q[k] <= vin[k];
          if (vin[k]) stg_q[k] <= stg_in[k];
        end
      end
    end
  end

  assign in_ready  = rdy[0] && !rst;
  assign out_valid = v_q[PIPE-1];
  assign out_count = stg_q[PIPE-1].count;
  assign out_flag  = stg_q[PIPE-1].flag;
  assign out_norm  = stg_q[PIPE-1].norm;
  assign out_tag   = stg_q[PIPE-1].tag;

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed bench for lzc_pipe: default 32-bit/2-stage instance plus an 8-bit/3-stage instance.
module tb_lzc_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_flag;
  logic [31:0] in_data, out_norm;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag, out_tag;
  logic [4:0]  out_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_flag;
  logic [7:0]  s_in_data, s_out_norm;
  logic [1:0]  s_in_mode;
  logic [3:0]  s_in_tag, s_out_tag;
  logic [2:0]  s_out_count;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  lzc_pipe #(.WIDTH(32), .PIPE(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_flag(out_flag), .out_norm(out_norm), .out_tag(out_tag)
  );

  lzc_pipe #(.WIDTH(8), .PIPE(3), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_mode(s_in_mode), .in_tag(s_in_tag), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_count(s_out_count), .out_flag(s_out_flag), .out_norm(s_out_norm), .out_tag(s_out_tag)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one operand on an idle pipe and check latency and result.
  task automatic do_one(input string name, input bit sel, input logic [1:0] mode,
                        input logic [31:0] data, input logic [3:0] tag, input int ecount,
                        input logic eflag, input logic [31:0] enorm, input int elat);
    int lat;
    if (sel) begin
      s_in_valid = 1'b1; s_in_mode = mode; s_in_data = data[7:0]; s_in_tag = tag;
    end else begin
      in_valid = 1'b1; in_mode = mode; in_data = data; in_tag = tag;
    end
    #1;
    chk({name, ".in_ready"}, sel ? s_in_ready : in_ready, 1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    lat = 0;
    while (!(sel ? s_out_valid : out_valid) && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, ".lat"},   lat, elat);
    chk({name, ".count"}, sel ? 64'(s_out_count) : 64'(out_count), ecount);
    chk({name, ".flag"},  sel ? s_out_flag : out_flag, eflag);
    chk({name, ".norm"},  sel ? 64'(s_out_norm) : 64'(out_norm), enorm);
    chk({name, ".tag"},   sel ? s_out_tag : out_tag, tag);
    @(posedge clk); #1;
  endtask

  initial begin
    int  sent, rcv, acc;
    bit  started;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mode = '0; s_in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_count", out_count, 0);
    chk("rst.out_flag",  out_flag, 0);
    chk("rst.out_norm",  out_norm, 0);
    chk("rst.out_tag",   out_tag, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_ready", in_ready, 1);

    do_one("lz_mid",    0, 2'd0, 32'h0001_0000, 4'd3, 15, 1'b0, 32'h8000_0000, 1);
    do_one("lz_zero",   0, 2'd0, 32'h0000_0000, 4'd5, 31, 1'b1, 32'h0000_0000, 1);
    do_one("lo_ones",   0, 2'd1, 32'hFFFF_FFFF, 4'd6, 31, 1'b1, 32'h8000_0000, 1);
    do_one("lo_12",     0, 2'd1, 32'hFFF0_0000, 4'd7, 12, 1'b0, 32'h0000_0000, 1);
    do_one("tz_9",      0, 2'd2, 32'h0000_0A00, 4'd8, 9,  1'b0, 32'h0000_0005, 1);
    do_one("tz_zero",   0, 2'd2, 32'h0000_0000, 4'd9, 31, 1'b1, 32'h0000_0000, 1);
    do_one("ls_16",     0, 2'd3, 32'hFFFF_8000, 4'd1, 16, 1'b0, 32'h8000_0000, 1);
    do_one("ls_30",     0, 2'd3, 32'h0000_0001, 4'd2, 30, 1'b0, 32'h4000_0000, 1);
    do_one("ls_allone", 0, 2'd3, 32'hFFFF_FFFF, 4'd4, 31, 1'b1, 32'h8000_0000, 1);
    do_one("ls_0",      0, 2'd3, 32'h7FFF_FFFF, 4'hA, 0,  1'b0, 32'h7FFF_FFFF, 1);
    do_one("lz_0",      0, 2'd0, 32'h8000_0000, 4'hB, 0,  1'b0, 32'h8000_0000, 1);

    do_one("w8_lz",    1, 2'd0, 32'h10, 4'd1, 3, 1'b0, 32'h80, 2);
    do_one("w8_tzz",   1, 2'd2, 32'h00, 4'd2, 7, 1'b1, 32'h00, 2);
    do_one("w8_ls",    1, 2'd3, 32'hF0, 4'd3, 3, 1'b0, 32'h80, 2);
    do_one("w8_lo",    1, 2'd1, 32'hC3, 4'd4, 2, 1'b0, 32'h0C, 2);
    do_one("w8_tz7",   1, 2'd2, 32'h80, 4'd5, 7, 1'b0, 32'h01, 2);

    // Streaming with a 4-cycle output stall in the middle.
    sent = 0; rcv = 0; started = 0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      in_valid  = (sent < 8);
      in_mode   = 2'd0;
      in_data   = 32'h1 << (sent * 3);
      in_tag    = 4'(sent);
      out_ready = !(cyc >= 4 && cyc < 8);
      #1;
      if (started) chk("stream.valid", out_valid, 1);
      if (out_valid) begin
        started = 1;
        chk("stream.tag",   out_tag, rcv);
        chk("stream.count", out_count, 31 - 3 * rcv);
        chk("stream.norm",  out_norm, 32'h8000_0000);
        if (out_ready) rcv++;
      end
      if (cyc == 7) chk("stall.in_ready", in_ready, 0);
      acc = int'(in_valid && in_ready);
      @(posedge clk); #1;
      if (acc != 0) sent++;
    end
    chk("stream.received", rcv, 8);
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset with two operands in flight.
    in_valid = 1'b1; in_mode = 2'd0; in_data = 32'h0000_0100; in_tag = 4'hA;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flight.out_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst.out_valid", out_valid, 0);
    chk("arst.out_count", out_count, 0);
    chk("arst.out_norm",  out_norm, 0);
    chk("arst.out_tag",   out_tag, 0);
    chk("arst.out_flag",  out_flag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst.in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("arst.no_stale", out_valid, 0);
      @(posedge clk); #1;
    end
    do_one("post_rst",  0, 2'd0, 32'h0000_00FF, 4'hC, 24, 1'b0, 32'hFF00_0000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
